// File: rtl/handshake_const_check.sv
// Sink that compares each accepted token to CONST_VALUE and queues a 1-bit match flag.
// Optional token/mismatch saturating counters: define HANDSHAKE_CONST_CHECK_STATS_EN.
module handshake_const_check #(
  parameter int DATA_WIDTH  = 32,
  parameter     CONST_VALUE = 32'h00000025,
  parameter int DEPTH       = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic                  mismatch_seen
`ifdef HANDSHAKE_CONST_CHECK_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  mismatch_cnt,
  output logic [CNT_WIDTH-1:0]  token_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_WIDTH-1:0] CMP_VAL = DATA_WIDTH'(CONST_VALUE);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   occ_q, occ_d;
  logic             mismatch_seen_q, mismatch_seen_d;
  logic             push, pop, match;

  // Ready depends only on registered occupancy, so a pop never frees a slot same-cycle.
  assign ins_ready     = (occ_q != FULL);
  assign outs_valid    = (occ_q != '0);
  assign outs          = outs_valid ? mem_q[rd_ptr_q] : 1'b0;
  assign mismatch_seen = mismatch_seen_q;

  assign match = (ins == CMP_VAL);
  assign push  = ins_valid && ins_ready;
  assign pop   = outs_valid && outs_ready;

  always_comb begin
    mem_d           = mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    occ_d           = occ_q;
    mismatch_seen_d = mismatch_seen_q;
    if (push) begin
      mem_d[wr_ptr_q] = match;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      if (!match) mismatch_seen_d = 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + (PTR_W+1)'(1);
      2'b01:   occ_d = occ_q - (PTR_W+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q           <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      occ_q           <= '0;
      mismatch_seen_q <= 1'b0;
    end else begin
      mem_q           <= mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      occ_q           <= occ_d;
      mismatch_seen_q <= mismatch_seen_d;
    end
  end

`ifdef HANDSHAKE_CONST_CHECK_STATS_EN
  logic [CNT_WIDTH-1:0] token_cnt_q, token_cnt_d, mismatch_cnt_q, mismatch_cnt_d;

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    token_cnt_d    = token_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    if (push && (token_cnt_q != '1)) token_cnt_d = token_cnt_q + CNT_WIDTH'(1);
    if (push && !match && (mismatch_cnt_q != '1)) mismatch_cnt_d = mismatch_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      token_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
    end else begin
      token_cnt_q    <= token_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
    end
  end

  assign token_cnt    = token_cnt_q;
  assign mismatch_cnt = mismatch_cnt_q;
`endif

endmodule
